// File: rtl/zone_pkg.sv
// Shared constants, FSM states and the zone banding helper for the
// 3x3 local-dimming brightness estimator.
package zone_pkg;

    localparam int ZONES      = 9;
    localparam int ZONE_IDX_W = 4;

    // Luma weights; they sum to 256 so full white maps exactly to 255.
    localparam logic [15:0] COEF_R = 16'd77;
    localparam logic [15:0] COEF_G = 16'd150;
    localparam logic [15:0] COEF_B = 16'd29;

    typedef enum logic [1:0] {
        ST_WAIT_VS,
        ST_ACCUM,
        ST_CALC,
        ST_UPDATE
    } state_e;

    // Maps a pixel coordinate to its zone band (0..2) with two comparators.
    function automatic logic [1:0] zone_band(input int unsigned pos, input int unsigned span);
        if (pos < span) begin
            return 2'd0;
        end else if (pos < 2 * span) begin
            return 2'd1;
        end
        return 2'd2;
    endfunction

endpackage

// File: rtl/zone_luma.sv
// Two-stage RGB888 -> 8-bit luma pipeline; valid and zone index travel
// alongside so they arrive together with the luma value.
module zone_luma
    import zone_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic [ZONE_IDX_W-1:0] zone_i,
    input  logic [7:0]            r_i,
    input  logic [7:0]            g_i,
    input  logic [7:0]            b_i,
    output logic                  valid_o,
    output logic [ZONE_IDX_W-1:0] zone_o,
    output logic [7:0]            y_o
);

    logic [15:0]           pr_q, pg_q, pb_q;
    logic                  valid1_q, valid2_q;
    logic [ZONE_IDX_W-1:0] zone1_q, zone2_q;
    logic [7:0]            y_q;

    // Stage 1 weights each channel, stage 2 sums and drops the 8 fraction bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pr_q     <= '0;
            pg_q     <= '0;
            pb_q     <= '0;
            valid1_q <= 1'b0;
            zone1_q  <= '0;
            y_q      <= '0;
            valid2_q <= 1'b0;
            zone2_q  <= '0;
        end else begin
            pr_q     <= COEF_R * 16'(r_i);
            pg_q     <= COEF_G * 16'(g_i);
            pb_q     <= COEF_B * 16'(b_i);
            valid1_q <= valid_i;
            zone1_q  <= zone_i;
            y_q      <= 8'((pr_q + pg_q + pb_q) >> 8);
            valid2_q <= valid1_q;
            zone2_q  <= zone1_q;
        end
    end

    assign valid_o = valid2_q;
    assign zone_o  = zone2_q;
    assign y_o     = y_q;

endmodule

// File: rtl/video_zone_brightness.sv
// Observes the received pixel stream and produces one backlight level per
// zone of a 3x3 grid each frame (zone peak or zone mean luma).
module video_zone_brightness
    import zone_pkg::*;
#(
    parameter int H_ACTIVE = 1024,
    parameter int V_ACTIVE = 768,
    parameter bit VS_POL   = 1'b1
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_vs,
    input  logic               I_hs,
    input  logic               I_de,
    input  logic [7:0]         I_data_r,
    input  logic [7:0]         I_data_g,
    input  logic [7:0]         I_data_b,
    input  logic               I_mode,
    output logic [8*ZONES-1:0] O_led_light,
    output logic               O_frame_done,
    output logic               O_frame_err
);

    localparam int ZW    = H_ACTIVE / 3;
    localparam int ZH    = V_ACTIVE / 3;
    localparam int ZPIX  = ZW * ZH;
    localparam int SUM_W = $clog2(ZPIX * 255 + 1);
    localparam int PW    = SUM_W + 33;
    localparam logic [32:0] RECIP = 33'((64'd1 << 32) / 64'(ZPIX));
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);
    localparam logic [ZONE_IDX_W-1:0] Z_LAST = ZONE_IDX_W'(ZONES - 1);

    state_e                state_q, state_d;
    logic                  vs_act, vs_q, vs_q2, vs_edge;
    logic                  de_eff, de_q, de_fall;
    logic [XW-1:0]         x_q;
    logic [YW-1:0]         y_q;
    logic                  in_range, pix_valid, pix_oor;
    logic [1:0]            row, col;
    logic [ZONE_IDX_W-1:0] pix_zone;
    logic                  luma_valid;
    logic [ZONE_IDX_W-1:0] luma_zone;
    logic [7:0]            luma_y;
    logic [SUM_W-1:0]      sum_q  [ZONES];
    logic [7:0]            peak_q [ZONES];
    logic [7:0]            shadow_q [ZONES];
    logic [ZONE_IDX_W-1:0] zidx_q;
    logic                  mode_q, mode_next_q, ovf_q, dirty_q;
    logic [8*ZONES-1:0]    led_q;
    logic                  done_q, err_q;
    logic                  start_frame, close_ok, close_bad, calc_en, update_en;
    logic [SUM_W:0]        mean_raw;
    logic [7:0]            mean_sat, level;
    logic                  unused_hs;

    assign unused_hs = I_hs;

    // Sync/DE qualification: DE during active VS is treated as blanking.
    assign vs_act    = (I_vs == VS_POL);
    assign vs_edge   = vs_q & ~vs_q2;
    assign de_eff    = I_de & ~vs_act;
    assign de_fall   = de_q & ~de_eff;
    assign in_range  = (x_q < X_END) && (y_q < Y_END);
    assign pix_valid = de_eff & in_range;
    assign pix_oor   = de_eff & ~in_range;
    assign row       = zone_band(32'(y_q), ZH);
    assign col       = zone_band(32'(x_q), ZW);
    assign pix_zone  = 4'(row) * 4'd3 + 4'(col);

    zone_luma u_luma (
        .clk_i   (I_clk),
        .rst_ni  (I_rst_n),
        .valid_i (pix_valid),
        .zone_i  (pix_zone),
        .r_i     (I_data_r),
        .g_i     (I_data_g),
        .b_i     (I_data_b),
        .valid_o (luma_valid),
        .zone_o  (luma_zone),
        .y_o     (luma_y)
    );

    // Edge detectors and saturating x/y pixel counters.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (!I_rst_n) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            de_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            vs_q  <= vs_act;
            vs_q2 <= vs_q;
            de_q  <= de_eff;
            if (vs_edge) begin
                x_q <= '0;
                y_q <= '0;
            end else if (de_fall) begin
                x_q <= '0;
                if (y_q < Y_END) y_q <= y_q + 1'b1;
            end else if (de_eff && (x_q < X_END)) begin
                x_q <= x_q + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) state_q <= ST_WAIT_VS;
        else          state_q <= state_d;
    end

    // FSM next state and per-cycle control strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_d     = state_q;
        start_frame = 1'b0;
        close_ok    = 1'b0;
        close_bad   = 1'b0;
        calc_en     = 1'b0;
        update_en   = 1'b0;
        unique case (state_q)
            ST_WAIT_VS: begin
                if (vs_edge) begin
                    start_frame = 1'b1;
                    state_d     = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (vs_edge) begin
                    if ((y_q == Y_END) && !ovf_q && !dirty_q) begin
                        close_ok = 1'b1;
                        state_d  = ST_CALC;
                    end else begin
                        close_bad   = 1'b1;
                        start_frame = 1'b1;
                    end
                end
            end
            ST_CALC: begin
                calc_en = 1'b1;
                if (zidx_q == Z_LAST) state_d = ST_UPDATE;
            end
            ST_UPDATE: begin
                update_en = 1'b1;
                state_d   = ST_ACCUM;
            end
            default: state_d = ST_WAIT_VS;
        endcase
    end

    // Shared mean multiplier: one zone per CALC cycle, saturated to 8 bits.
    assign mean_raw = (SUM_W + 1)'((PW'(sum_q[zidx_q]) * PW'(RECIP)) >> 32);
    assign mean_sat = (mean_raw > (SUM_W + 1)'(255)) ? 8'd255 : mean_raw[7:0];
    assign level    = mode_q ? mean_sat : peak_q[zidx_q];

    // Per-zone sum and peak accumulation for the frame in progress.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        // NOTE: the zone arrays are reset too, so the first frame after reset starts from zero.
        if (!I_rst_n) begin
            for (int z = 0; z < ZONES; z++) begin
                sum_q[z]  <= '0;
                peak_q[z] <= '0;
            end
        end else if (start_frame || update_en) begin
            for (int z = 0; z < ZONES; z++) begin
                sum_q[z]  <= '0;
                peak_q[z] <= '0;
            end
        end else if ((state_q == ST_ACCUM) && luma_valid) begin
            sum_q[luma_zone] <= sum_q[luma_zone] + SUM_W'(luma_y);
            if (luma_y > peak_q[luma_zone]) peak_q[luma_zone] <= luma_y;
        end
    end

    // Frame bookkeeping, level calculation into the shadow, and output update.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            dirty_q     <= 1'b0;
            mode_q      <= 1'b0;
            mode_next_q <= 1'b0;
            zidx_q      <= '0;
            led_q       <= '0;
            for (int z = 0; z < ZONES; z++) shadow_q[z] <= '0;
        end else begin
            done_q <= update_en;
            err_q  <= close_bad;
            // A VS edge always opens a new frame; one opened while CALC/UPDATE
            // still own the accumulators cannot be trusted.
            if (vs_edge) begin
                ovf_q   <= 1'b0;
                dirty_q <= (state_q == ST_CALC) || (state_q == ST_UPDATE);
            end else if (pix_oor) begin
                ovf_q <= 1'b1;
            end
            if (close_ok)         mode_next_q <= I_mode;
            if (start_frame)      mode_q      <= I_mode;
            else if (update_en)   mode_q      <= mode_next_q;
            if (calc_en) begin
                shadow_q[zidx_q] <= level;
                zidx_q           <= (zidx_q == Z_LAST) ? '0 : zidx_q + 1'b1;
            end
            if (update_en) begin
                for (int z = 0; z < ZONES; z++) led_q[8*z +: 8] <= shadow_q[z];
            end
        end
    end

    assign O_led_light  = led_q;
    assign O_frame_done = done_q;
    assign O_frame_err  = err_q;

endmodule
